// File: rtl/param_seq_ctrl.sv
// Parametrised up/down terminal counter with TC history shift register and a
// run/drain FSM, all flops on falling CK. Optional WRAPS counter: PARAM_SEQ_CTRL_WRAP_COUNT_EN.
module param_seq_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LIMIT   = 200,
    parameter int unsigned SHIFT_D = 6
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               EN,
    input  logic               MODE,
    output logic [CNT_W-1:0]   CNT,
    output logic               TC,
    output logic [SHIFT_D-1:0] SHIFT_Q,
    output logic [1:0]         STATE,
    output logic               DONE
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
    ,
    output logic [7:0]         WRAPS
`endif
);

    localparam int unsigned      DC_W    = $clog2(SHIFT_D);
    localparam logic [CNT_W-1:0] LIM     = CNT_W'(LIMIT);
    localparam logic [DC_W-1:0]  DC_LAST = DC_W'(SHIFT_D - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_DRAIN  = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SHIFT_D-1:0] r_shift, w_shift_nxt;
    logic [DC_W-1:0]    r_dcnt, w_dcnt_nxt;
    logic               r_done, w_done_nxt;
    logic               r_mode, w_mode_nxt;
    logic               w_tc;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
    logic [7:0]         r_wraps, w_wraps_nxt;
`endif

    // TC uses the direction sampled at the last edge so it has no input path
    assign w_tc = (r_state == S_RUN) && (r_mode ? (r_cnt == '0) : (r_cnt == LIM));

    always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_dcnt  <= '0;
            r_done  <= 1'b0;
            r_mode  <= 1'b0;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
            r_wraps <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_done  <= w_done_nxt;
            r_mode  <= w_mode_nxt;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
            r_wraps <= w_wraps_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_dcnt_nxt  = r_dcnt;
        w_done_nxt  = 1'b0;
        w_mode_nxt  = MODE;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
        w_wraps_nxt = r_wraps;
`endif
        if (CLR) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
            w_dcnt_nxt  = '0;
            w_mode_nxt  = 1'b0;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
            w_wraps_nxt = '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (EN) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_shift_nxt = {r_shift[SHIFT_D-2:0], w_tc};
                    if (MODE) w_cnt_nxt = (r_cnt == '0) ? LIM : r_cnt - CNT_W'(1);
                    else      w_cnt_nxt = (r_cnt == LIM) ? '0 : r_cnt + CNT_W'(1);
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
                    if (w_tc && (r_wraps != 8'hFF)) w_wraps_nxt = r_wraps + 8'd1;
`endif
                    if (!EN) begin
                        w_state_nxt = S_DRAIN;
                        w_dcnt_nxt  = '0;
                    end
                end
                S_DRAIN: begin
                    w_shift_nxt = {r_shift[SHIFT_D-2:0], 1'b0};
                    w_dcnt_nxt  = r_dcnt + DC_W'(1);
                    if (r_dcnt == DC_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_dcnt_nxt  = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign CNT     = r_cnt;
    assign TC      = w_tc;
    assign SHIFT_Q = r_shift;
    assign STATE   = r_state;
    assign DONE    = r_done;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
    assign WRAPS   = r_wraps;
`endif

endmodule

// File: tb/tb_param_seq_ctrl.sv
// Directed bench for param_seq_ctrl at CNT_W=4, LIMIT=9, SHIFT_D=4.
module tb_param_seq_ctrl;

    logic       CK = 1'b0;
    logic       RST, CLR, EN, MODE;
    logic [3:0] CNT;
    logic       TC;
    logic [3:0] SHIFT_Q;
    logic [1:0] STATE;
    logic       DONE;
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
    logic [7:0] WRAPS;
`endif

    int n_total = 0;
    int n_bad   = 0;

    param_seq_ctrl #(.CNT_W(4), .LIMIT(9), .SHIFT_D(4)) dut (
        .CK(CK), .RST(RST), .CLR(CLR), .EN(EN), .MODE(MODE),
        .CNT(CNT), .TC(TC), .SHIFT_Q(SHIFT_Q), .STATE(STATE), .DONE(DONE)
`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
        , .WRAPS(WRAPS)
`endif
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // advance one active (falling) edge, land 1 time unit after it
    task automatic step();
        @(negedge CK);
        #1;
    endtask

    task automatic check_all(input string tag, input int cnt, input int st,
                             input int sh, input int dn);
        check({tag, ".cnt"},   32'(CNT),     32'(cnt));
        check({tag, ".state"}, 32'(STATE),   32'(st));
        check({tag, ".shift"}, 32'(SHIFT_Q), 32'(sh));
        check({tag, ".done"},  32'(DONE),    32'(dn));
    endtask

    int exp_cnt;

    initial begin
        RST = 1'b1; CLR = 1'b0; EN = 1'b0; MODE = 1'b0;
        step(); step();
        RST = 1'b0;
        check_all("reset", 0, 0, 0, 0);
        check("reset.tc", 32'(TC), 0);

        // up count from IDLE: entry edge, 1..9, wrap to 0, then 1
        EN = 1'b1; MODE = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cnt = (k == 1) ? 0 : (k <= 10) ? k - 1 : k - 11;
            check($sformatf("up%0d.cnt", k), 32'(CNT), 32'(exp_cnt));
            check($sformatf("up%0d.tc", k), 32'(TC), (exp_cnt == 9) ? 1 : 0);
        end
        check("up.state", 32'(STATE), 1);
        check("up.shift", 32'(SHIFT_Q), 32'h2);

        // one more up edge to 2, then switch to down
        step();
        check("pre_dn.cnt", 32'(CNT), 2);
        MODE = 1'b1;
        step(); check("dn1.cnt", 32'(CNT), 1); check("dn1.tc", 32'(TC), 0);
        step(); check("dn2.cnt", 32'(CNT), 0); check("dn2.tc", 32'(TC), 1);
        step(); check("dn3.cnt", 32'(CNT), 9); check("dn3.tc", 32'(TC), 0);
        step(); check("dn4.cnt", 32'(CNT), 8); check("dn4.tc", 32'(TC), 0);
        check("dn.shift", 32'(SHIFT_Q), 32'h2);

        // down to 4, then drop EN with MODE up
        for (int k = 0; k < 4; k++) step();
        check("pre_drain.cnt", 32'(CNT), 4);
        EN = 1'b0; MODE = 1'b0;
        step();
        check_all("drain0", 5, 2, 0, 0);
        check("drain0.tc", 32'(TC), 0);
        step(); check_all("drain1", 5, 2, 0, 0);
        EN = 1'b1;
        step(); check_all("drain2", 5, 2, 0, 0);
        EN = 1'b0;
        step(); check_all("drain3", 5, 2, 0, 0);
        step(); check_all("drain_done", 5, 0, 0, 1);
        step(); check_all("post_done", 5, 0, 0, 0);

        // CLR beats EN during RUN at CNT=7
        EN = 1'b1;
        step(); step(); step();
        check("pre_clr.cnt", 32'(CNT), 7);
        check("pre_clr.state", 32'(STATE), 1);
        CLR = 1'b1;
        step();
        check_all("clr", 0, 0, 0, 0);
        CLR = 1'b0; EN = 1'b0;
        step();
        check_all("post_clr", 0, 0, 0, 0);

        // asynchronous reset mid-run at CNT=5, no clock edge
        EN = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("pre_rst.cnt", 32'(CNT), 5);
        check("pre_rst.state", 32'(STATE), 1);
        #2 RST = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        EN = 1'b0;
        step();
        RST = 1'b0;
        check_all("rst_hold", 0, 0, 0, 0);

`ifdef PARAM_SEQ_CTRL_WRAP_COUNT_EN
        check("wraps.reset", 32'(WRAPS), 0);
        EN = 1'b1; MODE = 1'b0;
        for (int k = 0; k < 11; k++) step();
        check("wraps.first", 32'(WRAPS), 1);
        for (int k = 0; k < 3000; k++) step();
        check("wraps.sat", 32'(WRAPS), 255);
        CLR = 1'b1;
        step();
        CLR = 1'b0; EN = 1'b0;
        check("wraps.clr", 32'(WRAPS), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/param_seq_ctrl.md
Name: param_seq_ctrl

Overview:
- Parametrised successor to the team's fixed-width clocked-netlist controllers.
- Combines a configurable up/down terminal counter, a terminal-count history shift register, and a three-state run/drain FSM behind a small control interface.
- Sits in the sequential benchmark suite as a scalable instance: width, limit and depth are adjusted through parameters, not by re-synthesising a netlist.
- All state flops sample on the falling edge of CK, as the existing flop cells do.

Parameters:
- CNT_W, 8, counter width in bits (2..16).
- LIMIT, 200, terminal value; counter range is 0..LIMIT; requires LIMIT < 2**CNT_W and LIMIT >= 1.
- SHIFT_D, 6, depth of TC history shift register and length of the drain phase (2..32).

Ports:
- CK  input  1  clock; all state updates on negedge CK.
- RST  input  1  asynchronous active-high reset.
- CLR  input  1  synchronous clear; takes priority over every other input except RST.
- EN  input  1  run request.
- MODE  input  1  0 = count up, 1 = count down.
- CNT  output  CNT_W  current counter value.
- TC  output  1  terminal-count flag; decoded from registers, no combinational path from inputs.
- SHIFT_Q  output  SHIFT_D  TC history; bit 0 is the newest.
- STATE  output  2  FSM state: 00 IDLE, 01 RUN, 10 DRAIN; 11 is unused.
- DONE  output  1  one-cycle pulse at the end of drain.

Behaviour:
- Reset: RST=1 forces, asynchronously, CNT=0, SHIFT_Q=0, STATE=IDLE, DONE=0 and the internal drain counter to 0. The flops hold these values while RST=1.
- CLR=1 at a falling edge: same values as reset, applied synchronously. It overrides EN and MODE.
- TC = 1 only when STATE==RUN and the counter is at its wrap point:
  - up mode: CNT==LIMIT;
  - down mode: CNT==0.
- IDLE:
  - CNT and SHIFT_Q hold; DONE=0.
  - EN=1 at an edge moves to RUN; CNT is not updated at that edge.
- RUN, at every edge:
  - SHIFT_Q <= {SHIFT_Q[SHIFT_D-2:0], TC};
  - CNT updates by mode:
    - up: CNT==LIMIT gives CNT <= 0, otherwise CNT+1;
    - down: CNT==0 gives CNT <= LIMIT, otherwise CNT-1.
- MODE is sampled every edge. A direction change takes effect at the same edge, so no extra latency.
- RUN with EN=0 at an edge moves to DRAIN:
  - the CNT update and the shift still occur at that edge;
  - the drain counter loads 0.
- DRAIN:
  - CNT holds; SHIFT_Q shifts in 0 each edge; the drain counter increments.
  - After SHIFT_D drain edges (drain counter == SHIFT_D-1 at the edge), DONE=1 for the next cycle and STATE=IDLE.
  - SHIFT_Q is all-zero on exit.
- EN during DRAIN is ignored. Restart requires EN=1 while in IDLE; the earliest re-entry to RUN is the edge after DONE is asserted.
- DONE clears at the following edge unconditionally.
- Unused STATE 11 returns to IDLE at the next edge with CNT and SHIFT_Q unchanged.
- Arithmetic wraps only at the defined boundaries; CNT never exceeds LIMIT.

Optional Feature:
- Macro: PARAM_SEQ_CTRL_WRAP_COUNT_EN.
- Defined:
  - adds output WRAPS [7:0];
  - WRAPS increments at each RUN edge where TC=1 and saturates at 255;
  - WRAPS is cleared by RST and by CLR, and holds in IDLE and DRAIN.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
All scenarios use CNT_W=4, LIMIT=9, SHIFT_D=4.
1. Assert RST mid-run with CNT=5 and no clock edge -> CNT=0, STATE=00, SHIFT_Q=0000, DONE=0 immediately.
2. EN=1, MODE=0, 12 edges from IDLE -> edge 1 enters RUN; CNT steps 1..9, then 0, 1; TC=1 only while CNT=9; SHIFT_Q shows 1 shifted in at the wrap.
3. MODE=1 from CNT=2 in RUN -> CNT 1, 0, 9, 8; TC=1 while CNT=0; wrap to LIMIT confirmed.
4. Drop EN in RUN at CNT=4 -> STATE=DRAIN with CNT=5; 4 edges later DONE=1 for one cycle, STATE=IDLE, SHIFT_Q=0000; EN pulsed during drain has no effect.
5. CLR=1 together with EN=1 during RUN at CNT=7 -> next edge CNT=0, STATE=IDLE, SHIFT_Q=0000.
6. With PARAM_SEQ_CTRL_WRAP_COUNT_EN, run up-mode for 300 wraps -> WRAPS=255, saturated; CLR -> WRAPS=0.
